// File: rtl/o_serializer_oe.sv
// o_serializer_oe: registered parallel-to-serial pad driver with tri-state enable and valid/ready intake
module o_serializer_oe #(
  parameter int    DATA_WIDTH    = 4,
  parameter string BIT_ORDER     = "LSB_FIRST",
  parameter logic  IDLE_VALUE    = 1'b0,
  parameter string TRISTATE_IDLE = "TRUE"
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  input  logic                  OE_IN,
  output logic                  DATA_READY,
  output logic                  Q,
  output logic                  T_OUT,
  output logic                  BUSY,
  output logic                  UNDERRUN
);
  if (DATA_WIDTH < 2 || DATA_WIDTH > 10) begin : g_bad_width
    $fatal(1, "%m: DATA_WIDTH=%0d illegal, legal range 2..10", DATA_WIDTH);
  end
  if (BIT_ORDER != "LSB_FIRST" && BIT_ORDER != "MSB_FIRST") begin : g_bad_order
    $fatal(1, "%m: BIT_ORDER=\"%s\" illegal, legal values \"LSB_FIRST\" or \"MSB_FIRST\"", BIT_ORDER);
  end
  if (TRISTATE_IDLE != "TRUE" && TRISTATE_IDLE != "FALSE") begin : g_bad_tri
    $fatal(1, "%m: TRISTATE_IDLE=\"%s\" illegal, legal values \"TRUE\" or \"FALSE\"", TRISTATE_IDLE);
  end
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic lsb_first = (BIT_ORDER == "LSB_FIRST");
  localparam logic tri_idle = (TRISTATE_IDLE == "TRUE");
  localparam logic [CW-1:0] last_cnt = CW'(DATA_WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n;
  logic oe, oe_n, q_n, t_n, und_n, last, accept;
  assign last = (state == SHIFT) && (cnt == last_cnt);
  assign DATA_READY = RST && ((state == IDLE) || last);
  assign accept = DATA_VALID && DATA_READY;
  assign BUSY = (state == SHIFT);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sreg_n = sreg;
    oe_n = oe;
    q_n = Q;
    t_n = T_OUT;
    und_n = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      cnt_n = '0;
      sreg_n = lsb_first ? DATA_IN >> 1 : DATA_IN << 1;
      q_n = lsb_first ? DATA_IN[0] : DATA_IN[DATA_WIDTH-1];
      oe_n = OE_IN;
      t_n = OE_IN;
    end else if (last) begin
      state_n = IDLE;
      cnt_n = '0;
      q_n = IDLE_VALUE;
      t_n = tri_idle ? 1'b0 : oe;
      und_n = 1'b1;
    end else if (state == SHIFT) begin
      cnt_n = cnt + 1'b1;
      sreg_n = lsb_first ? sreg >> 1 : sreg << 1;
      q_n = lsb_first ? sreg[0] : sreg[DATA_WIDTH-1];
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
      oe <= 1'b0;
      Q <= IDLE_VALUE;
      T_OUT <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sreg <= sreg_n;
      oe <= oe_n;
      Q <= q_n;
      T_OUT <= t_n;
      UNDERRUN <= und_n;
    end
  end
endmodule
